// File: rtl/host_cmd_parser_pkg.sv
// Shared host command constants, header layout and parser state encoding.
// Imported by the host command parser and by its testbench.
package host_cmd_parser_pkg;

   localparam logic [7:0] CMD_PING   = 8'h00;
   localparam logic [7:0] CMD_WRITE  = 8'h01;
   localparam logic [7:0] CMD_READ   = 8'h02;
   localparam logic [7:0] CMD_CONFIG = 8'h03;
   localparam logic [7:0] HDR_MAGIC  = 8'hCD;

   localparam int HDR_WORD_CMD   = 0;
   localparam int HDR_WORD_COUNT = 1;
   localparam int HDR_WORD_ADDR  = 2;
   localparam int HDR_WORDS      = 3;

   typedef enum logic [2:0] {
      ST_HDR0,
      ST_HDR1,
      ST_HDR2,
      ST_ISSUE,
      ST_DATA,
      ST_FLUSH
   } parse_state_t;

   // Only writes and non-empty configs carry payload; a zero-count write carries none.
   function automatic logic has_payload(input logic [7:0] command, input logic [31:0] rw_count);
      return (rw_count != 32'd0) && ((command == CMD_WRITE) || (command == CMD_CONFIG));
   endfunction

endpackage

// File: rtl/host_cmd_parser_if.sv
// Host command parser boundary: ping-pong ingress, command issue and payload forwarding.
// The master modport is the parser side; slave is the surrounding logic.
interface host_cmd_parser_if #(
   parameter int MAX_PKT_BITS = 24
);

   logic                    i_rd_ready;
   logic                    o_rd_activate;
   logic [MAX_PKT_BITS-1:0] i_rd_size;
   logic [31:0]             i_rd_data;
   logic                    o_rd_stb;
   logic                    i_master_ready;
   logic [7:0]              o_command;
   logic [7:0]              o_flag;
   logic [31:0]             o_rw_count;
   logic [31:0]             o_address;
   logic                    o_command_rdy_stb;
   logic [31:0]             o_wdata;
   logic                    o_wdata_stb;
   logic                    i_wdata_ready;
   logic                    o_error_stb;
   logic                    o_busy;

   modport master (
      input  i_rd_ready, i_rd_size, i_rd_data, i_master_ready, i_wdata_ready,
      output o_rd_activate, o_rd_stb, o_command, o_flag, o_rw_count, o_address,
             o_command_rdy_stb, o_wdata, o_wdata_stb, o_error_stb, o_busy
   );

   modport slave (
      output i_rd_ready, i_rd_size, i_rd_data, i_master_ready, i_wdata_ready,
      input  o_rd_activate, o_rd_stb, o_command, o_flag, o_rw_count, o_address,
             o_command_rdy_stb, o_wdata, o_wdata_stb, o_error_stb, o_busy
   );

endinterface

// File: rtl/host_cmd_parser_ppfifo_word_reader.sv
// Ping-pong FIFO packet ownership: activate, count pops, release once the packet is drained.
// Word available combinationally from owned-and-not-exhausted; one pop per cycle.
module ppfifo_word_reader #(
   parameter int SIZE_BITS = 24
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rd_ready,
   input  logic [SIZE_BITS-1:0] rd_size,
   input  logic                 pop,
   output logic                 activate,
   output logic                 avail,
   output logic                 last
);

   logic [SIZE_BITS-1:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         activate <= 1'b0;
         count    <= '0;
      end else if (!activate) begin
         if (rd_ready) begin
            activate <= 1'b1;
            count    <= '0;
         end
      end else if (pop) begin
         count <= count + SIZE_BITS'(1);
      end else if (count == rd_size) begin
         // Release wins over a waiting rd_ready; re-activation follows next cycle.
         activate <= 1'b0;
      end
   end

   assign avail = activate && (count < rd_size);
   assign last  = avail && (count == rd_size - SIZE_BITS'(1));

endmodule

// File: rtl/host_cmd_parser.sv
// Parses 3-word host headers from the ingress FIFO, issues them to the master and forwards payload.
// Bad magic pulses an error and discards the rest of that ingress packet.
module host_cmd_parser
   import host_cmd_parser_pkg::*;
#(
   parameter logic [7:0] MAGIC        = HDR_MAGIC,
   parameter int         MAX_PKT_BITS = 24
) (
   input  logic           clk,
   input  logic           rst,
   host_cmd_parser_if.master bus
);

   parse_state_t state;
   parse_state_t state_nxt;

   logic        rd_activate;
   logic        avail;
   logic        last;
   logic        pop;
   logic        issue;
   logic        magic_ok;

   logic [7:0]  command;
   logic [7:0]  flag;
   logic [31:0] rw_count;
   logic [31:0] address;
   logic [31:0] remaining;
   logic [31:0] wdata;
   logic        wdata_stb;
   logic        error_stb;

   ppfifo_word_reader #(
      .SIZE_BITS (MAX_PKT_BITS)
   ) u_reader (
      .clk      (clk),
      .rst      (rst),
      .rd_ready (bus.i_rd_ready),
      .rd_size  (bus.i_rd_size),
      .pop      (pop),
      .activate (rd_activate),
      .avail    (avail),
      .last     (last)
   );

   assign magic_ok = (bus.i_rd_data[31:24] == MAGIC);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_HDR0;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      issue     = 1'b0;
      case (state)
         ST_HDR0: begin
            if (avail) begin
               pop       = 1'b1;
               state_nxt = magic_ok ? ST_HDR1 : ST_FLUSH;
            end
         end
         ST_HDR1: begin
            if (avail) begin
               pop       = 1'b1;
               state_nxt = ST_HDR2;
            end
         end
         ST_HDR2: begin
            if (avail) begin
               pop       = 1'b1;
               state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (bus.i_master_ready) begin
               issue     = 1'b1;
               state_nxt = has_payload(command, rw_count) ? ST_DATA : ST_HDR0;
            end
         end
         ST_DATA: begin
            if (avail && bus.i_wdata_ready) begin
               pop = 1'b1;
               if (remaining == 32'd1) begin
                  state_nxt = ST_HDR0;
               end
            end
         end
         ST_FLUSH: begin
            // Nothing left to drain (or no packet owned) means we are resynchronised.
            if (avail) begin
               pop = 1'b1;
               if (last) begin
                  state_nxt = ST_HDR0;
               end
            end else begin
               state_nxt = ST_HDR0;
            end
         end
         default: state_nxt = ST_HDR0;
      endcase
      if (rst) begin
         pop   = 1'b0;
         issue = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         command   <= '0;
         flag      <= '0;
         rw_count  <= '0;
         address   <= '0;
         remaining <= '0;
         wdata     <= '0;
         wdata_stb <= 1'b0;
         error_stb <= 1'b0;
      end else begin
         wdata_stb <= 1'b0;
         error_stb <= 1'b0;
         if (pop) begin
            case (state)
               ST_HDR0: begin
                  if (magic_ok) begin
                     command <= bus.i_rd_data[7:0];
                     flag    <= bus.i_rd_data[23:16];
                  end else begin
                     error_stb <= 1'b1;
                  end
               end
               ST_HDR1: rw_count <= bus.i_rd_data;
               ST_HDR2: address  <= bus.i_rd_data;
               ST_DATA: begin
                  wdata     <= bus.i_rd_data;
                  wdata_stb <= 1'b1;
                  remaining <= remaining - 32'd1;
               end
               default: ;
            endcase
         end
         if (issue) begin
            remaining <= rw_count;
         end
      end
   end

   assign bus.o_rd_activate     = rd_activate;
   assign bus.o_rd_stb          = pop;
   assign bus.o_command         = command;
   assign bus.o_flag            = flag;
   assign bus.o_rw_count        = rw_count;
   assign bus.o_address         = address;
   assign bus.o_command_rdy_stb = issue;
   assign bus.o_wdata           = wdata;
   assign bus.o_wdata_stb       = wdata_stb;
   assign bus.o_error_stb       = error_stb;
   assign bus.o_busy            = (state != ST_HDR0);

endmodule

// File: tb/tb_host_cmd_parser.sv
// Bench for host_cmd_parser: FIFO emulator plus a word-stream reference model.
module tb_host_cmd_parser;
   import host_cmd_parser_pkg::*;

   typedef struct packed {
      logic [7:0]  cmd;
      logic [7:0]  flag;
      logic [31:0] cnt;
      logic [31:0] addr;
   } exp_cmd_t;

   localparam int K_HDR      = 0;
   localparam int K_HDR_LAST = 1;
   localparam int K_PAY      = 2;
   localparam int K_BAD      = 3;
   localparam int K_FLUSH    = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   host_cmd_parser_if #(.MAX_PKT_BITS(24)) bus ();

   host_cmd_parser dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] words[$];
   int          sizes[$];
   int          kinds[$];
   exp_cmd_t    cmd_q[$];
   int          exp_errs;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive_idle();
      bus.i_rd_ready     = 1'b0;
      bus.i_rd_size      = '0;
      bus.i_rd_data      = '0;
      bus.i_master_ready = 1'b0;
      bus.i_wdata_ready  = 1'b0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      drive_idle();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_activate", bus.o_rd_activate, 0);
      check("rst_rd_stb", bus.o_rd_stb, 0);
      check("rst_command", bus.o_command, 0);
      check("rst_flag", bus.o_flag, 0);
      check("rst_rw_count", bus.o_rw_count, 0);
      check("rst_address", bus.o_address, 0);
      check("rst_cmd_stb", bus.o_command_rdy_stb, 0);
      check("rst_wdata", bus.o_wdata, 0);
      check("rst_wdata_stb", bus.o_wdata_stb, 0);
      check("rst_error_stb", bus.o_error_stb, 0);
      check("rst_busy", bus.o_busy, 0);
   endtask

   // Classify every word of the stream from the header rules; bad magic eats its packet.
   task automatic build_model();
      int pend[$];
      int base = 0;
      int i = 0;
      kinds.delete();
      cmd_q.delete();
      exp_errs = 0;
      foreach (sizes[p]) begin
         for (int j = 0; j < sizes[p]; j++) pend.push_back(base + sizes[p]);
         base += sizes[p];
      end
      for (int j = 0; j < words.size(); j++) kinds.push_back(K_FLUSH);
      while (i < words.size()) begin
         if (words[i][31:24] != HDR_MAGIC) begin
            kinds[i] = K_BAD;
            exp_errs++;
            i = pend[i];
         end else if (i + HDR_WORDS <= words.size()) begin
            exp_cmd_t c;
            c.cmd  = words[i + HDR_WORD_CMD][7:0];
            c.flag = words[i + HDR_WORD_CMD][23:16];
            c.cnt  = words[i + HDR_WORD_COUNT];
            c.addr = words[i + HDR_WORD_ADDR];
            kinds[i + HDR_WORD_CMD]   = K_HDR;
            kinds[i + HDR_WORD_COUNT] = K_HDR;
            kinds[i + HDR_WORD_ADDR]  = K_HDR_LAST;
            cmd_q.push_back(c);
            i += HDR_WORDS;
            if (c.cmd == CMD_WRITE || c.cmd == CMD_CONFIG) begin
               for (int n = 0; n < int'(c.cnt) && i < words.size(); n++) begin
                  kinds[i] = K_PAY;
                  i++;
               end
            end
         end else begin
            break;
         end
      end
   endtask

   task automatic run_stream(input int mprob, input int wprob, input int mdelay,
                             input int stall_after, input int stall_len, input int rst_after_pay);
      int       cur = 0;
      int       base = 0;
      int       idx = 0;
      int       npk;
      int       nw;
      int       mcnt = 0;
      int       scnt = 0;
      int       pay_pops = 0;
      int       prev_cur = -1;
      int       ncmd = 0;
      int       errs_seen = 0;
      int       g;
      logic     prev_act = 1'b0;
      logic     s_pop = 1'b0;
      logic     exp_wstb = 1'b0;
      logic     exp_err = 1'b0;
      logic     pending = 1'b0;
      logic     arm = 1'b0;
      logic     prev_pay = 1'b0;
      logic     ok;
      logic     done = 1'b0;
      logic     aborted = 1'b0;
      logic [31:0] exp_wdata = '0;
      exp_cmd_t last_cmd = '0;
      build_model();
      npk = sizes.size();
      nw  = words.size();
      for (int cyc = 0; cyc < 3000 + 40 * nw && !done && !aborted; cyc++) begin
         @(negedge clk);
         if (s_pop) idx++;
         if (prev_act && !bus.o_rd_activate) begin
            check("release_end", idx, sizes[cur]);
            base += sizes[cur];
            cur++;
            idx = 0;
         end
         prev_act = bus.o_rd_activate;
         if (arm) begin
            pending = 1'b1;
            mcnt    = mdelay;
            arm     = 1'b0;
         end
         bus.i_rd_ready = (cur < npk);
         bus.i_rd_size  = (cur < npk) ? 24'(sizes[cur]) : 24'd0;
         bus.i_rd_data  = (cur < npk && idx < sizes[cur]) ? words[base + idx] : $urandom;
         if (pending && mcnt > 0) begin
            bus.i_master_ready = 1'b0;
            mcnt--;
         end else begin
            bus.i_master_ready = ($urandom_range(99) < mprob);
         end
         if (scnt > 0) begin
            bus.i_wdata_ready = 1'b0;
            scnt--;
         end else begin
            bus.i_wdata_ready = ($urandom_range(99) < wprob);
         end
         #1;
         s_pop = bus.o_rd_stb;
         check("wdata_stb", bus.o_wdata_stb, exp_wstb);
         if (exp_wstb) check("wdata", bus.o_wdata, exp_wdata);
         check("error_stb", bus.o_error_stb, exp_err);
         if (bus.o_error_stb) errs_seen++;
         check("cmd_stb", bus.o_command_rdy_stb, pending && bus.i_master_ready);
         if (prev_pay && cur == prev_cur && cur < npk && idx < sizes[cur] &&
             kinds[base + idx] == K_PAY && bus.i_wdata_ready)
            check("throughput", s_pop, 1);
         exp_wstb = 1'b0;
         exp_err  = 1'b0;
         prev_pay = 1'b0;
         if (s_pop) begin
            ok = bus.o_rd_activate && cur < npk && idx < sizes[cur];
            check("pop_avail", ok, 1);
            check("pop_in_issue", pending, 0);
            if (ok) begin
               g = base + idx;
               case (kinds[g])
                  K_PAY: begin
                     check("pay_ready", bus.i_wdata_ready, 1);
                     exp_wstb  = 1'b1;
                     exp_wdata = words[g];
                     prev_pay  = 1'b1;
                     prev_cur  = cur;
                     pay_pops++;
                     if (pay_pops == stall_after) scnt = stall_len;
                  end
                  K_BAD:      exp_err = 1'b1;
                  K_HDR_LAST: arm = 1'b1;
                  default: ;
               endcase
            end
         end
         if (bus.o_command_rdy_stb && pending) begin
            if (ncmd < cmd_q.size()) begin
               check("command", bus.o_command, cmd_q[ncmd].cmd);
               check("flag", bus.o_flag, cmd_q[ncmd].flag);
               check("rw_count", bus.o_rw_count, cmd_q[ncmd].cnt);
               check("address", bus.o_address, cmd_q[ncmd].addr);
               last_cmd = cmd_q[ncmd];
            end
            ncmd++;
            pending = 1'b0;
         end
         if (rst_after_pay > 0 && pay_pops == rst_after_pay) begin
            aborted = 1'b1;
         end
         done = (cur == npk) && !pending && !arm && !exp_wstb && !exp_err && !bus.o_busy;
      end
      if (aborted) begin
         apply_reset();
      end else begin
         check("finished", done, 1);
         check("error_count", errs_seen, exp_errs);
         check("cmd_count", ncmd, cmd_q.size());
         if (ncmd > 0) begin
            check("hold_command", bus.o_command, last_cmd.cmd);
            check("hold_rw_count", bus.o_rw_count, last_cmd.cnt);
            check("hold_address", bus.o_address, last_cmd.addr);
         end
         check("idle_busy", bus.o_busy, 0);
      end
   endtask

   task automatic gen_random();
      logic [31:0] tmp[$];
      int nseg;
      nseg = 2 + $urandom_range(4);
      words.delete();
      sizes.delete();
      for (int s = 0; s < nseg; s++) begin
         if ($urandom_range(4) == 0) begin
            int         sz;
            logic [7:0] top;
            sz  = 1 + $urandom_range(4);
            top = 8'($urandom);
            if (top == HDR_MAGIC) top = 8'h5A;
            words.push_back({top, 24'($urandom)});
            for (int j = 1; j < sz; j++) words.push_back($urandom);
            sizes.push_back(sz);
         end else begin
            int nc;
            nc = 1 + $urandom_range(2);
            tmp.delete();
            for (int c = 0; c < nc; c++) begin
               logic [7:0]  op;
               logic [31:0] cnt;
               case ($urandom_range(4))
                  0:       op = CMD_PING;
                  1:       op = CMD_WRITE;
                  2:       op = CMD_READ;
                  3:       op = CMD_CONFIG;
                  default: op = 8'h40 + 8'($urandom_range(63));
               endcase
               cnt = (op == CMD_WRITE || op == CMD_CONFIG) ? 32'($urandom_range(6)) : $urandom;
               tmp.push_back({HDR_MAGIC, 8'($urandom), 8'($urandom), op});
               tmp.push_back(cnt);
               tmp.push_back($urandom);
               if (op == CMD_WRITE || op == CMD_CONFIG)
                  for (int n = 0; n < int'(cnt); n++) tmp.push_back($urandom);
            end
            while (tmp.size() > 0) begin
               int sz;
               sz = $urandom_range(5);
               if (sz > tmp.size()) sz = tmp.size();
               sizes.push_back(sz);
               repeat (sz) words.push_back(tmp.pop_front());
            end
         end
      end
   endtask

   initial begin
      drive_idle();
      apply_reset();

      // ping
      words = '{32'hCD000000, 32'd0, 32'd0};
      sizes = '{3};
      run_stream(100, 100, 0, 0, 0, 0);

      // four-word write, downstream stalls three cycles after the second word
      words = '{32'hCD000001, 32'd4, 32'h1000, 32'hA, 32'hB, 32'hC, 32'hD};
      sizes = '{7};
      run_stream(100, 100, 0, 2, 3, 0);

      // header split across packets
      sizes = '{1, 6};
      run_stream(100, 100, 0, 0, 0, 0);

      // bad magic packet followed by a ping
      words = '{32'hAB000001, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'hCD000000, 32'd0, 32'd0};
      sizes = '{6, 3};
      run_stream(100, 100, 0, 0, 0, 0);

      // master busy for ten cycles after the header
      words = '{32'hCD000001, 32'd4, 32'h1000, 32'hA, 32'hB, 32'hC, 32'hD};
      sizes = '{7};
      run_stream(100, 100, 10, 0, 0, 0);

      // reset after two of four payload words, then a fresh ping
      run_stream(100, 100, 0, 0, 0, 2);
      words = '{32'hCD000000, 32'd0, 32'd0};
      sizes = '{3};
      run_stream(100, 100, 0, 0, 0, 0);

      for (int r = 0; r < 12; r++) begin
         gen_random();
         run_stream(30 + $urandom_range(70), 30 + $urandom_range(70), $urandom_range(3), 0, 0, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
